// File: rtl/regfile_ctl.sv
// General-purpose register bank: one-hot decoded write port, two registered
// read ports with optional same-edge forwarding, and a sequenced clear-all sweep.
module regfile_ctl #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [WIDTH-1:0]  rd_a_q, rd_a_d;
  logic [WIDTH-1:0]  rd_b_q, rd_b_d;
  logic [DEPTH-1:0]  wr_onehot;
  logic [DEPTH-1:0]  clr_onehot;
  logic              wr_accept;

  // Write and clear enables are one-hot and never active in the same state.
  always_comb begin
    wr_accept  = wr_en && (state_q == ST_IDLE);
    wr_onehot  = '0;
    clr_onehot = '0;
    if (wr_accept) wr_onehot[wr_addr] = 1'b1;
    if (state_q == ST_CLEAR) clr_onehot[idx_q] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (clr_onehot[i])     mem_d[i] = '0;
      else if (wr_onehot[i]) mem_d[i] = wr_data;
    end
  end

  always_comb begin
    rd_a_d = mem_q[rd_addr_a];
    rd_b_d = mem_q[rd_addr_b];
    if (BYPASS != 0) begin
      if (wr_onehot[rd_addr_a])       rd_a_d = wr_data;
      else if (clr_onehot[rd_addr_a]) rd_a_d = '0;
      if (wr_onehot[rd_addr_b])       rd_b_d = wr_data;
      else if (clr_onehot[rd_addr_b]) rd_b_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        idx_d = idx_q + ADDR_W'(1);
        if (&idx_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign rd_data_a = rd_a_q;
  assign rd_data_b = rd_b_q;
  assign clr_busy  = (state_q == ST_CLEAR);
  assign clr_done  = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_ctl.sv
// Bench for regfile_ctl: two instances (forwarding on/off) share stimulus and are
// compared against an array-based model plus table vectors and corner sequences.
module tb_regfile_ctl;
  localparam int W  = 16;
  localparam int AW = 3;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [AW-1:0] rd_addr_a = '0;
  logic [AW-1:0] rd_addr_b = '0;
  logic          clr_req = 1'b0;

  logic [W-1:0]  rd_a1, rd_b1, rd_a0, rd_b0;
  logic          busy1, done1, dbg1, busy0, done0, dbg0;

  always #5 clk = ~clk;

  regfile_ctl #(.WIDTH(W), .ADDR_W(AW), .BYPASS(1)) dut_byp (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_a1), .rd_addr_b(rd_addr_b), .rd_data_b(rd_b1),
    .clr_req(clr_req), .clr_busy(busy1), .clr_done(done1), .dbg_state(dbg1)
  );

  regfile_ctl #(.WIDTH(W), .ADDR_W(AW), .BYPASS(0)) dut_nob (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_a0), .rd_addr_b(rd_addr_b), .rd_data_b(rd_b0),
    .clr_req(clr_req), .clr_busy(busy0), .clr_done(done0), .dbg_state(dbg0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: register contents, cycles of sweep left, next sweep slot.
  logic [W-1:0] m_mem [D];
  int           m_left;
  int           m_pos;
  logic         m_done;
  logic [W-1:0] m_a1, m_b1, m_a0, m_b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) m_mem[i] = '0;
    m_left = 0; m_pos = 0; m_done = 1'b0;
    m_a1 = '0; m_b1 = '0; m_a0 = '0; m_b0 = '0;
  endtask

  function automatic logic [W-1:0] fwd(input int ra, input bit acc, input int cpos);
    if (acc && int'(wr_addr) == ra) return wr_data;
    if (cpos == ra) return '0;
    return m_mem[ra];
  endfunction

  task automatic model_edge();
    bit in_clr;
    bit acc;
    int cpos;
    in_clr = (m_left > 0);
    acc    = wr_en && !in_clr;
    cpos   = in_clr ? m_pos : -1;
    m_a1 = fwd(int'(rd_addr_a), acc, cpos);
    m_b1 = fwd(int'(rd_addr_b), acc, cpos);
    m_a0 = m_mem[rd_addr_a];
    m_b0 = m_mem[rd_addr_b];
    if (acc) m_mem[wr_addr] = wr_data;
    m_done = 1'b0;
    if (in_clr) begin
      m_mem[m_pos] = '0;
      m_pos++;
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (clr_req) begin
      m_left = D;
      m_pos  = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_rda_byp"}, rd_a1, m_a1);
    check({tag, "_rdb_byp"}, rd_b1, m_b1);
    check({tag, "_rda_nob"}, rd_a0, m_a0);
    check({tag, "_rdb_nob"}, rd_b0, m_b0);
    check({tag, "_busy_byp"}, W'(busy1), W'(m_left > 0));
    check({tag, "_busy_nob"}, W'(busy0), W'(m_left > 0));
    check({tag, "_done_byp"}, W'(done1), W'(m_done));
    check({tag, "_done_nob"}, W'(done0), W'(m_done));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    model_edge();
    check_all(tag);
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic set_wr(input logic we, input int wa, input logic [W-1:0] wd);
    wr_en = we; wr_addr = AW'(wa); wr_data = wd;
  endtask

  // Counts busy cycles and done pulses of a sweep requested on the next edge.
  task automatic run_sweep(input int extra_req_at, output int bc, output int dc);
    clr_req = 1'b1;
    step("sweep_req");
    clr_req = 1'b0;
    bc = int'(busy1);
    dc = int'(done1);
    for (int c = 0; c < 12; c++) begin
      clr_req = (c == extra_req_at);
      if (c == 2)      set_wr(1'b1, 6, 16'hFFFF);
      else if (c == 5) set_wr(1'b1, 0, 16'hFFFF);
      else             set_wr(1'b0, 0, '0);
      rd_addr_a = AW'(c); rd_addr_b = AW'(7 - (c % 8));
      step("sweep");
      bc += int'(busy1);
      dc += int'(done1);
    end
    idle_inputs();
  endtask

  task automatic read_all_zero(input string tag);
    for (int i = 0; i < D; i++) begin
      rd_addr_a = AW'(i); rd_addr_b = AW'(D - 1 - i);
      step(tag);
      check({tag, "_a_zero"}, rd_a1, '0);
      check({tag, "_b_zero"}, rd_b0, '0);
    end
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [W-1:0]  ea1, eb1, ea0, eb0;
  } vec_t;

  vec_t vecs [6];
  int   bc, dc;

  initial begin
    vecs[0] = '{1'b1, 3'd5, 16'h1234, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 3'd2, 16'hBEEF, 3'd5, 3'd2, 16'h1234, 16'hBEEF, 16'h1234, 16'h0000};
    vecs[2] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd2, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF};
    vecs[3] = '{1'b0, 3'd0, 16'h0000, 3'd1, 3'd7, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[4] = '{1'b1, 3'd3, 16'hA5A5, 3'd3, 3'd4, 16'hA5A5, 16'h0000, 16'h0000, 16'h0000};
    vecs[5] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5};

    // Clock and reset.
    model_reset();
    #3;
    check("rst_rda", rd_a1, '0);
    check("rst_busy", W'(busy1), '0);
    check("rst_done", W'(done0), '0);
    #8 rst_n = 1'b1;

    // Table vectors: write/read and same-edge forwarding.
    foreach (vecs[i]) begin
      set_wr(vecs[i].we, int'(vecs[i].wa), vecs[i].wd);
      rd_addr_a = vecs[i].ra; rd_addr_b = vecs[i].rb;
      step("tbl");
      check("tbl_a_byp", rd_a1, vecs[i].ea1);
      check("tbl_b_byp", rd_b1, vecs[i].eb1);
      check("tbl_a_nob", rd_a0, vecs[i].ea0);
      check("tbl_b_nob", rd_b0, vecs[i].eb0);
    end
    idle_inputs();

    // Reset with registers preloaded.
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("prst_rda", rd_a1, '0);
    check("prst_rdb", rd_b0, '0);
    #2 rst_n = 1'b1;
    read_all_zero("prst");

    // Full sweep with writes dropped mid-sweep.
    for (int i = 0; i < D; i++) begin
      set_wr(1'b1, i, W'(16'h1111 * (i + 1)));
      step("fill");
    end
    idle_inputs();
    run_sweep(-1, bc, dc);
    check("sweep_busy_cycles", W'(bc), W'(8));
    check("sweep_done_pulses", W'(dc), W'(1));
    read_all_zero("after_sweep");

    // Second request during a sweep is not queued.
    for (int i = 0; i < D; i++) begin
      set_wr(1'b1, i, W'(16'h0F0F + i));
      step("fill2");
    end
    idle_inputs();
    run_sweep(3, bc, dc);
    check("dup_busy_cycles", W'(bc), W'(8));
    check("dup_done_pulses", W'(dc), W'(1));

    // Request and write to addr 0 on the same idle edge.
    set_wr(1'b1, 0, 16'h7777);
    clr_req = 1'b1;
    rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    step("cw_req");
    check("cw_req_byp", rd_a1, 16'h7777);
    check("cw_req_nob", rd_a0, 16'h0000);
    idle_inputs();
    step("cw_clr0");
    check("cw_clr0_byp", rd_a1, 16'h0000);
    check("cw_clr0_nob", rd_a0, 16'h7777);
    for (int i = 0; i < 9; i++) step("cw_tail");
    step("cw_read");
    check("cw_final", rd_a0, 16'h0000);

    // Reset at sweep index 4.
    set_wr(1'b1, 7, 16'h5555);
    step("mr_fill");
    set_wr(1'b0, 0, '0);
    clr_req = 1'b1;
    step("mr_req");
    clr_req = 1'b0;
    for (int i = 0; i < 4; i++) step("mr_sweep");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("mr_busy_drop", W'(busy1), '0);
    check("mr_done_low", W'(done1), '0);
    #2 rst_n = 1'b1;
    dc = 0;
    for (int i = 0; i < 12; i++) begin
      step("mr_after");
      dc += int'(done1) + int'(done0);
    end
    check("mr_no_done", W'(dc), '0);
    read_all_zero("mr");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      set_wr(1'($urandom_range(0, 1)), int'($urandom_range(0, D - 1)), W'($urandom_range(0, 16'hFFFF)));
      rd_addr_a = AW'($urandom_range(0, D - 1));
      rd_addr_b = AW'($urandom_range(0, D - 1));
      clr_req   = ($urandom_range(0, 19) == 0);
      step("rnd");
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
